// File: rtl/addsub_seq.sv
// addsub_seq: wide add/subtract built from NUM passes through a shared
// WIDTH-bit add/sub unit, one chunk per cycle, LSB chunk first.
module addsub_seq #(
    parameter int WIDTH = 4,
    parameter int NUM   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH*NUM-1:0]   req_a,
    input  logic [WIDTH*NUM-1:0]   req_b,
    input  logic                   req_sub,
    input  logic                   req_cin,
    output logic [WIDTH-1:0]       dp_a,
    output logic [WIDTH-1:0]       dp_b,
    output logic                   dp_cin,
    output logic                   dp_sub,
    input  logic [WIDTH-1:0]       dp_sum,
    input  logic                   dp_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH*NUM-1:0]   rsp_result,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic                   busy
);

    localparam int OW = WIDTH * NUM;
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          sub_q, sub_d;
    logic [OW-1:0] a_q, a_d;
    logic [OW-1:0] b_q, b_d;
    logic [OW-1:0] res_q, res_d;

    logic in_run;
    logic in_done;
    logic last;
    logic ovf_raw;

    assign in_run  = (state_q == RUN);
    assign in_done = (state_q == DONE);
    assign last    = (idx_q == IW'(NUM - 1));

    // Shared unit is only driven while a chunk is actually being computed.
    always_comb begin
        dp_a   = '0;
        dp_b   = '0;
        dp_cin = 1'b0;
        dp_sub = 1'b0;
        if (in_run) begin
            dp_a   = a_q[idx_q*WIDTH +: WIDTH];
            dp_b   = b_q[idx_q*WIDTH +: WIDTH];
            dp_cin = carry_q;
            dp_sub = sub_q;
        end
    end

    // Overflow from sign bits of the operands and the finished result.
    always_comb begin
        if (sub_q) begin
            ovf_raw = (a_q[OW-1] != b_q[OW-1]) && (res_q[OW-1] != a_q[OW-1]);
        end else begin
            ovf_raw = (a_q[OW-1] == b_q[OW-1]) && (res_q[OW-1] != a_q[OW-1]);
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = in_done;
    assign rsp_result = in_done ? res_q : '0;
    assign rsp_cout   = in_done ? carry_q : 1'b0;
    assign rsp_ovf    = in_done ? ovf_raw : 1'b0;

    // Next-state: accept in IDLE, ripple one chunk per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sub_d   = req_sub;
                    carry_d = req_cin;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q*WIDTH +: WIDTH] = dp_sum;
                carry_d = dp_cout;
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed vectors plus stall and mid-run reset sequences,
// with a behavioural model of the shared add/sub unit.
module tb_addsub_seq;

    localparam int WIDTH = 4;
    localparam int NUM   = 4;
    localparam int OW    = WIDTH * NUM;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [OW-1:0]    req_a;
    logic [OW-1:0]    req_b;
    logic             req_sub;
    logic             req_cin;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_cin;
    logic             dp_sub;
    logic [WIDTH-1:0] dp_sum;
    logic             dp_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OW-1:0]    rsp_result;
    logic             rsp_cout;
    logic             rsp_ovf;
    logic             busy;

    logic [WIDTH:0]   unit_t;

    int tests;
    int fails;

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          sub;
        logic          cin;
        logic [OW-1:0] res;
        logic          cout;
        logic          ovf;
    } vec_t;

    addsub_seq #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .req_cin    (req_cin),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_cin     (dp_cin),
        .dp_sub     (dp_sub),
        .dp_sum     (dp_sum),
        .dp_cout    (dp_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared unit model: add gives carry-out, subtract gives borrow-out.
    always_comb begin
        if (dp_sub) begin
            unit_t = {1'b0, dp_a} - {1'b0, dp_b} - {{WIDTH{1'b0}}, dp_cin};
        end else begin
            unit_t = {1'b0, dp_a} + {1'b0, dp_b} + {{WIDTH{1'b0}}, dp_cin};
        end
    end
    assign dp_sum  = unit_t[WIDTH-1:0];
    assign dp_cout = unit_t[WIDTH];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v);
        int n;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_a     = v.a;
        req_b     = v.b;
        req_sub   = v.sub;
        req_cin   = v.cin;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        chk("busy_run", {31'b0, busy}, 32'd1);
        wait_rsp(n);
        chk("latency", n, NUM);
        chk("result", {16'b0, rsp_result}, {16'b0, v.res});
        chk("cout", {31'b0, rsp_cout}, {31'b0, v.cout});
        chk("ovf", {31'b0, rsp_ovf}, {31'b0, v.ovf});
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   n;

        vecs[0] = '{a: 16'h1234, b: 16'h0FFF, sub: 1'b0, cin: 1'b0,
                    res: 16'h2233, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, sub: 1'b0, cin: 1'b1,
                    res: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 16'h0004, b: 16'h0005, sub: 1'b1, cin: 1'b0,
                    res: 16'hFFFF, cout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, cin: 1'b0,
                    res: 16'h7FFF, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, cin: 1'b0,
                    res: 16'h8000, cout: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 16'h1234, b: 16'h1234, sub: 1'b1, cin: 1'b1,
                    res: 16'hFFFF, cout: 1'b1, ovf: 1'b0};
        rv      = '{a: 16'h00A5, b: 16'h005A, sub: 1'b0, cin: 1'b0,
                    res: 16'h00FF, cout: 1'b0, ovf: 1'b0};

        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 1'b0;
        req_cin   = 1'b0;
        rsp_ready = 1'b0;

        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_cout", {31'b0, rsp_cout}, 32'd0);
        chk("rst_ovf", {31'b0, rsp_ovf}, 32'd0);
        chk("rst_result", {16'b0, rsp_result}, 32'd0);
        chk("rst_dp_a", {28'b0, dp_a}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i]);
        end

        // Stall in DONE with a competing request held on the input.
        @(negedge clk);
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        req_sub   = 1'b0;
        req_cin   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 16'h0100;
        req_b = 16'h0023;
        chk("dp_a_run0", {28'b0, dp_a}, 32'h1);
        chk("dp_b_run0", {28'b0, dp_b}, 32'h2);
        wait_rsp(n);
        chk("stall_latency", n, NUM);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_result", {16'b0, rsp_result}, 32'h3333);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_dp_a", {28'b0, dp_a}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("hs_busy", {31'b0, busy}, 32'd0);
        chk("hs_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("post_hs_accept", {31'b0, busy}, 32'd1);
        wait_rsp(n);
        chk("second_latency", n, NUM);
        chk("second_result", {16'b0, rsp_result}, 32'h0123);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset after two RUN edges abandons the operation.
        req_a     = 16'hFFFF;
        req_b     = 16'h0001;
        req_sub   = 1'b0;
        req_cin   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_dp_a", {28'b0, dp_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (NUM + 2) begin
            @(negedge clk);
            chk("no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        apply(rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bit width of one datapath chunk (the shared add/sub unit width).
REQ-002 The block SHALL have parameter NUM, default 4: number of chunks per operand, so operand width OW = WIDTH*NUM (16 by default).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port req_valid, input, 1: request present.
REQ-006 Port req_ready, output, 1: block accepts a request this cycle.
REQ-007 Ports req_a and req_b, input, OW each: operands.
REQ-008 Port req_sub, input, 1: 0 = add, 1 = subtract.
REQ-009 Port req_cin, input, 1: carry-in (add) or borrow-in (subtract).
REQ-010 Ports dp_a and dp_b, output, WIDTH each: chunk operands to the shared add/sub unit.
REQ-011 Ports dp_cin and dp_sub, output, 1 each: carry/borrow-in and mode to the unit.
REQ-012 Ports dp_sum (input, WIDTH) and dp_cout (input, 1): unit result.
- Unit contract: sub=0 gives {cout,sum} = a+b+cin.
- Unit contract: sub=1 gives sum = a-b-cin, with cout = borrow-out.
- The unit is purely combinational.
REQ-013 Port rsp_valid, output, 1: result available.
REQ-014 Port rsp_ready, input, 1: consumer takes the result.
REQ-015 Port rsp_result, output, OW: full-width result.
REQ-016 Port rsp_cout, output, 1: final carry-out (add) or borrow-out (subtract).
REQ-017 Port rsp_ovf, output, 1: signed two's-complement overflow.
REQ-018 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-020 IDLE behaviour:
- req_ready=1.
- On req_valid, register req_a, req_b, req_sub; set carry register to req_cin; set chunk index to 0; go to RUN.
REQ-021 RUN, combinational drive:
- dp_a/dp_b = chunk[idx] of the registered operands (chunk 0 = LSBs).
- dp_cin = carry register; dp_sub = registered mode.
REQ-022 RUN, each rising edge:
- Store dp_sum into result chunk[idx]; carry register <= dp_cout.
- If idx = NUM-1, go to DONE; otherwise increment idx.
- RUN therefore lasts exactly NUM cycles.
REQ-023 DONE behaviour:
- rsp_valid=1, with rsp_result, rsp_cout (= final carry register) and rsp_ovf stable until the rsp_valid && rsp_ready edge.
- On that edge, go to IDLE.
REQ-024 Latency: a request accepted at edge E SHALL present rsp_valid=1 after edge E+NUM; the earliest next accept is the edge after the response handshake.
REQ-025 req_ready SHALL be 0 in RUN and DONE; req_valid in those states is ignored and no input is sampled.
REQ-026 Overflow, with s = bit OW-1:
- add: rsp_ovf = (a.s==b.s) && (result.s!=a.s).
- sub: rsp_ovf = (a.s!=b.s) && (result.s!=a.s).
REQ-027 In IDLE and DONE, dp_a, dp_b, dp_cin and dp_sub SHALL be 0.
REQ-028 Result chunks not yet written in the current operation SHALL NOT appear on rsp_result; rsp_result is valid only while rsp_valid=1.

Reset
REQ-029 While rst=1, the block SHALL immediately, with no clock, enter:
- state IDLE, idx=0, carry=0;
- all operand and result registers 0;
- rsp_valid=0, rsp_cout=0, rsp_ovf=0, busy=0;
- req_ready=1 after reset release.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no response; the first request after release SHALL complete correctly.

Verification
REQ-031 The bench SHALL model the unit per REQ-012 and cover at least these scenarios:
- Add 0x1234+0x0FFF, cin=0 -> rsp_result=0x2233, cout=0, ovf=0; rsp_valid rises exactly 4 edges after accept.
- Add 0xFFFF+0x0000, cin=1 -> 0x0000, cout=1, ovf=0 (carry ripples through all 4 chunks).
- Sub 0x0004-0x0005, cin=0 -> 0xFFFF, cout=1 (borrow), ovf=0; sub 0x8000-0x0001 -> 0x7FFF, cout=0, ovf=1.
- Add 0x7FFF+0x0001, cin=0 -> 0x8000, cout=0, ovf=1.
- Hold rsp_ready=0 for 3 cycles in DONE while req_valid=1 -> response stays stable, req_ready=0, no new accept; accept occurs only after the response handshake.
- Assert rst after 2 RUN edges -> busy=0 and rsp_valid=0 immediately; then 0x00A5+0x005A -> 0x00FF, cout=0, ovf=0.
